// File: rtl/fp_conv_pkg.sv
// Shared definitions for the fp32 -> int64 converter.
//   state_e     : converter sequencing states
//   BIAS        : single-precision exponent bias
//   INT64_MAX/MIN : saturation values for invalid conversions
//   *_BIT/*_MSB/*_LSB : IEEE-754 single field positions
package fp_conv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    ROUND,
    DONE
  } state_e;

  localparam int unsigned BIAS = 127;

  localparam logic [63:0] INT64_MAX = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] INT64_MIN = 64'h8000_0000_0000_0000;

  localparam int unsigned SIGN_BIT = 31;
  localparam int unsigned EXP_MSB  = 30;
  localparam int unsigned EXP_LSB  = 23;
  localparam int unsigned FRAC_MSB = 22;
  localparam int unsigned FRAC_LSB = 0;

endpackage

// File: rtl/f2i_round_rne.sv
// Combinational rounding/negation stage of the fp32 -> int64 converter.
//   mag_i    : aligned integer magnitude
//   guard_i  : first bit below the integer lsb
//   sticky_i : OR of all bits below guard
//   sign_i   : operand sign; result is negated when set
//   rtz_i    : suppress the round-up (truncate toward zero)
//   result_o : rounded two's-complement result
//   inx_o    : any nonzero bit was discarded
module f2i_round_rne (
  input  logic [63:0] mag_i,
  input  logic        guard_i,
  input  logic        sticky_i,
  input  logic        sign_i,
  input  logic        rtz_i,
  output logic [63:0] result_o,
  output logic        inx_o
);

  logic        inc;
  logic [63:0] rounded;

  always_comb begin
    // Nearest-even: round up above half, or on an exact half when lsb is odd.
    inc      = guard_i & (sticky_i | mag_i[0]) & ~rtz_i;
    rounded  = mag_i + {63'b0, inc};
    result_o = sign_i ? (~rounded + 64'd1) : rounded;
    inx_o    = guard_i | sticky_i;
  end

endmodule

// File: rtl/fp32_to_int64_conv.sv
// Multi-cycle IEEE-754 single -> signed 64-bit integer converter.
// Aligns the mantissa one bit per cycle, then rounds to nearest-even.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : operand handshake, in_data = fp32 operand
//   out_valid/out_ready   : result handshake, out_data = int64 result
//   zf, nf                : result zero / result negative
//   inv                   : NaN, infinity or overflow (saturated result)
//   inx                   : nonzero bits discarded by rounding
// Optional: define F2I_RTZ_EN to add input rtz (truncate toward zero,
// sampled with in_data at acceptance).
module fp32_to_int64_conv #(
  parameter int unsigned RSHIFT_CAP = 26,
  parameter int unsigned BIAS       = 127
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        zf,
  output logic        nf,
  output logic        inv,
  output logic        inx
`ifdef F2I_RTZ_EN
  ,
  input  logic        rtz
`endif
);

  import fp_conv_pkg::*;

  logic rtz_in;
`ifdef F2I_RTZ_EN
  assign rtz_in = rtz;
`else
  assign rtz_in = 1'b0;
`endif

  state_e      state_q, state_d;
  logic [31:0] data_q, data_d;
  logic        rtz_q, rtz_d;
  logic [63:0] mag_q, mag_d;
  logic        guard_q, guard_d;
  logic        sticky_q, sticky_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        left_q, left_d;
  logic        spec_q, spec_d;
  logic        spec_inv_q, spec_inv_d;
  logic [63:0] out_data_q, out_data_d;
  logic        zf_q, zf_d;
  logic        nf_q, nf_d;
  logic        inv_q, inv_d;
  logic        inx_q, inx_d;

  // Operand decode
  logic              sign_w;
  logic [7:0]        exp_w;
  logic [22:0]       frac_w;
  logic signed [9:0] e_w;
  logic signed [9:0] rsh_w;

  assign sign_w = data_q[SIGN_BIT];
  assign exp_w  = data_q[EXP_MSB:EXP_LSB];
  assign frac_w = data_q[FRAC_MSB:FRAC_LSB];
  assign e_w    = $signed({2'b00, exp_w}) - $signed(10'(BIAS));
  assign rsh_w  = 10'sd23 - e_w;

  logic [63:0] rnd_result;
  logic        rnd_inx;
  logic [63:0] result_w;

  f2i_round_rne u_round (
    .mag_i    (mag_q),
    .guard_i  (guard_q),
    .sticky_i (sticky_q),
    .sign_i   (data_q[SIGN_BIT]),
    .rtz_i    (rtz_q),
    .result_o (rnd_result),
    .inx_o    (rnd_inx)
  );

  // Special cases hold the final value in mag_q and bypass the rounder.
  assign result_w = spec_q ? mag_q : rnd_result;

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    rtz_d      = rtz_q;
    mag_d      = mag_q;
    guard_d    = guard_q;
    sticky_d   = sticky_q;
    cnt_d      = cnt_q;
    left_d     = left_q;
    spec_d     = spec_q;
    spec_inv_d = spec_inv_q;
    out_data_d = out_data_q;
    zf_d       = zf_q;
    nf_d       = nf_q;
    inv_d      = inv_q;
    inx_d      = inx_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          rtz_d   = rtz_in;
          state_d = LOAD;
        end
      end

      LOAD: begin
        mag_d      = {40'b0, 1'b1, frac_w};
        guard_d    = 1'b0;
        sticky_d   = 1'b0;
        cnt_d      = '0;
        left_d     = 1'b0;
        spec_d     = 1'b0;
        spec_inv_d = 1'b0;
        if (exp_w == 8'd0) begin
          // Zero/denormal flushes to zero; any fraction bits are inexact.
          mag_d    = '0;
          sticky_d = |frac_w;
        end else if (exp_w == 8'hFF) begin
          spec_d     = 1'b1;
          spec_inv_d = 1'b1;
          mag_d      = (sign_w && (frac_w == 23'd0)) ? INT64_MIN : INT64_MAX;
        end else if (e_w >= 10'sd63) begin
          spec_d = 1'b1;
          if (sign_w && (e_w == 10'sd63) && (frac_w == 23'd0)) begin
            mag_d      = INT64_MIN;
            spec_inv_d = 1'b0;
          end else begin
            mag_d      = sign_w ? INT64_MIN : INT64_MAX;
            spec_inv_d = 1'b1;
          end
        end else if (e_w >= 10'sd23) begin
          left_d = 1'b1;
          cnt_d  = 6'(e_w - 10'sd23);
        end else begin
          cnt_d = (rsh_w > $signed(10'(RSHIFT_CAP))) ? 6'(RSHIFT_CAP) : 6'(rsh_w);
        end
        state_d = (cnt_d == 6'd0) ? ROUND : SHIFT;
      end

      SHIFT: begin
        if (left_q) begin
          mag_d = {mag_q[62:0], 1'b0};
        end else begin
          mag_d    = {1'b0, mag_q[63:1]};
          guard_d  = mag_q[0];
          sticky_d = sticky_q | guard_q;
        end
        cnt_d = cnt_q - 6'd1;
        if (cnt_q == 6'd1) begin
          state_d = ROUND;
        end
      end

      ROUND: begin
        out_data_d = result_w;
        zf_d       = (result_w == 64'd0);
        nf_d       = result_w[63];
        inv_d      = spec_q & spec_inv_q;
        inx_d      = ~spec_q & rnd_inx;
        state_d    = DONE;
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      data_q     <= '0;
      rtz_q      <= 1'b0;
      mag_q      <= '0;
      guard_q    <= 1'b0;
      sticky_q   <= 1'b0;
      cnt_q      <= '0;
      left_q     <= 1'b0;
      spec_q     <= 1'b0;
      spec_inv_q <= 1'b0;
      out_data_q <= '0;
      zf_q       <= 1'b0;
      nf_q       <= 1'b0;
      inv_q      <= 1'b0;
      inx_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      rtz_q      <= rtz_d;
      mag_q      <= mag_d;
      guard_q    <= guard_d;
      sticky_q   <= sticky_d;
      cnt_q      <= cnt_d;
      left_q     <= left_d;
      spec_q     <= spec_d;
      spec_inv_q <= spec_inv_d;
      out_data_q <= out_data_d;
      zf_q       <= zf_d;
      nf_q       <= nf_d;
      inv_q      <= inv_d;
      inx_q      <= inx_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = out_data_q;
  assign zf        = zf_q;
  assign nf        = nf_q;
  assign inv       = inv_q;
  assign inx       = inx_q;

endmodule

// File: tb/tb_fp32_to_int64_conv.sv
module tb_fp32_to_int64_conv;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        zf, nf, inv, inx;
`ifdef F2I_RTZ_EN
  logic        rtz;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  // Flags packed as {zf, nf, inv, inx}
  typedef struct {
    logic [31:0] d;
    logic [63:0] q;
    logic [3:0]  f;
    int          lat;
  } vec_t;

  fp32_to_int64_conv #(.RSHIFT_CAP(26), .BIAS(127)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .zf        (zf),
    .nf        (nf),
    .inv       (inv),
    .inx       (inx)
`ifdef F2I_RTZ_EN
    ,
    .rtz       (rtz)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Waits for in_ready, presents one operand, and counts rising edges from
  // the acceptance edge until out_valid is seen (bounded).
  task automatic run_op(input logic [31:0] d, output int lat);
    int g;
    g = 0;
    while (!in_ready && g < 60) begin
      @(posedge clk); #1; g++;
    end
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_chk++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
    n_chk++;
    if (out_data !== 64'd0 || {zf, nf, inv, inx} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_out: data=%h flags=%b want 0/0000", out_data, {zf, nf, inv, inx});
    end
  endtask

  task automatic test_vec_list(input string name, input vec_t v[$]);
    int lat;
    foreach (v[i]) begin
      run_op(v[i].d, lat);
      n_chk++;
      if (lat !== v[i].lat) begin
        n_fail++;
        $display("FAIL %s_lat[%h]: got %0d want %0d", name, v[i].d, lat, v[i].lat);
      end
      n_chk++;
      if (out_data !== v[i].q) begin
        n_fail++;
        $display("FAIL %s_data[%h]: got %h want %h", name, v[i].d, out_data, v[i].q);
      end
      n_chk++;
      if ({zf, nf, inv, inx} !== v[i].f) begin
        n_fail++;
        $display("FAIL %s_flags[%h]: got %b want %b", name, v[i].d, {zf, nf, inv, inx}, v[i].f);
      end
      release_result();
    end
  endtask

  task automatic test_rounding();
    vec_t v[$];
    v.push_back('{32'h3FC00000, 64'd2,                  4'b0001, 25}); // 1.5 tie -> 2
    v.push_back('{32'h40200000, 64'd2,                  4'b0001, 24}); // 2.5 tie -> 2
    v.push_back('{32'hC0400000, 64'hFFFF_FFFF_FFFF_FFFD, 4'b0100, 24}); // -3.0
    v.push_back('{32'hBFC00000, 64'hFFFF_FFFF_FFFF_FFFE, 4'b0101, 25}); // -1.5 -> -2
    v.push_back('{32'h3F400000, 64'd1,                  4'b0001, 26}); // 0.75 -> 1
    test_vec_list("round", v);
  endtask

  task automatic test_range();
    vec_t v[$];
    v.push_back('{32'h5E800000, 64'h4000_0000_0000_0000, 4'b0000, 41}); // 2^62
    v.push_back('{32'hDF000000, 64'h8000_0000_0000_0000, 4'b0100, 2});  // -2^63 exact
    v.push_back('{32'h5F000000, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0010, 2});  // +2^63 overflow
    v.push_back('{32'h4B800001, 64'h0000_0000_0100_0002, 4'b0000, 3});  // 2^24+2, k=1
    test_vec_list("range", v);
  endtask

  task automatic test_special();
    vec_t v[$];
    v.push_back('{32'h7FC00000, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0010, 2}); // NaN
    v.push_back('{32'hFF800000, 64'h8000_0000_0000_0000, 4'b0110, 2}); // -inf
    v.push_back('{32'h7F800000, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0010, 2}); // +inf
    v.push_back('{32'h00000001, 64'd0,                  4'b1001, 2}); // denormal
    v.push_back('{32'h80000000, 64'd0,                  4'b1000, 2}); // -0
    test_vec_list("special", v);
  endtask

  task automatic test_tiny();
    vec_t v[$];
    v.push_back('{32'h3F000000, 64'd0, 4'b1001, 26}); // 0.5 tie -> 0
    v.push_back('{32'h3E800000, 64'd0, 4'b1001, 27}); // 0.25
    v.push_back('{32'h00800000, 64'd0, 4'b1001, 28}); // min normal, capped shift
    test_vec_list("tiny", v);
  endtask

  task automatic test_backpressure();
    int lat;
    run_op(32'h40200000, lat);
    n_chk++;
    if (lat !== 24 || out_data !== 64'd2) begin
      n_fail++;
      $display("FAIL bp_first: lat=%0d data=%h want 24/2", lat, out_data);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_chk++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== 64'd2 ||
          {zf, nf, inv, inx} !== 4'b0001) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: ov=%b ir=%b data=%h flags=%b want 1/0/2/0001",
                 i, out_valid, in_ready, out_data, {zf, nf, inv, inx});
      end
    end
    // Offer a new operand during the take cycle; it must not be accepted.
    in_valid  = 1'b1;
    in_data   = 32'h3F800000;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    n_chk++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: ov=%b ir=%b want 0/1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    n_chk++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_no_overlap: in_ready=%b want 1", in_ready);
    end
  endtask

  task automatic test_reset_midop();
    int lat;
    in_valid = 1'b1;
    in_data  = 32'h3FC00000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 64'd0 ||
        {zf, nf, inv, inx} !== 4'b0000) begin
      n_fail++;
      $display("FAIL midop_reset: ir=%b ov=%b data=%h flags=%b want 1/0/0/0000",
               in_ready, out_valid, out_data, {zf, nf, inv, inx});
    end
    #3;
    rst_n = 1'b1;
    run_op(32'h3F800000, lat);
    n_chk++;
    if (lat !== 25 || out_data !== 64'd1 || {zf, nf, inv, inx} !== 4'b0000) begin
      n_fail++;
      $display("FAIL midop_after: lat=%0d data=%h flags=%b want 25/1/0000",
               lat, out_data, {zf, nf, inv, inx});
    end
    release_result();
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
`ifdef F2I_RTZ_EN
    rtz       = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_rounding();
    test_range();
    test_special();
    test_tiny();
    test_backpressure();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fp32_to_int64_conv.md
Name: fp32_to_int64_conv

Overview:
- Multi-cycle converter that unpacks an IEEE-754 single-precision value into a 64-bit two's-complement integer.
- Sits between the float unit's 32-bit result bus and the 64-bit integer ALU operand path; it is the decode side of the float packing the FPU performs.
- One bit of alignment shift per cycle; round-to-nearest-even, the same rounding rule the FPU uses.
- Valid/ready on both sides; one conversion in flight.

Parameters:
- RSHIFT_CAP, 26, maximum right-shift cycles; beyond this every mantissa bit has reached sticky.
- BIAS, 127, single-precision exponent bias.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_data is valid
- in_ready  output  1  converter can accept an operand
- in_data  input  32  IEEE-754 single operand
- out_valid  output  1  result is valid
- out_ready  input  1  consumer accepts the result
- out_data  output  64  signed integer result
- zf  output  1  out_data == 0
- nf  output  1  out_data[63]
- inv  output  1  NaN, infinity or overflow; result saturated
- inx  output  1  nonzero bits discarded by rounding

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-low (rst_n).
- Reset values: state IDLE; in_ready=1; out_valid=0; out_data=0; zf=0, nf=0, inv=0, inx=0.
- States: IDLE, LOAD, SHIFT, ROUND, DONE.
- IDLE: in_ready=1. in_valid&in_ready in cycle N latches in_data; go to LOAD. in_ready is 0 in every other state.
- LOAD: decode sign s, field E, and e=E-BIAS. Magnitude register = {40'b0,1'b1,frac}, with guard/sticky cleared.
  - Shift count k = e-23 (left) when e>=23, else min(23-e, RSHIFT_CAP) (right).
  - E=0 (zero or denormal, flushed to zero): k=0, result 0, inx = |frac.
  - E=255: k=0, inv=1. NaN or +inf gives 64'h7FFF_FFFF_FFFF_FFFF; -inf gives 64'h8000_0000_0000_0000.
  - e>=63: k=0, inv=1, saturate by sign. Exception: s=1, e=63, frac=0 gives exactly 64'h8000_0000_0000_0000 with inv=0.
- SHIFT: one bit per cycle for k cycles.
  - Left shift fills zeros.
  - Right shift: guard <= magnitude bit 0; sticky <= sticky|guard.
  - k=0 skips straight to ROUND.
- ROUND: increment the magnitude if guard & (sticky | lsb). inx = guard|sticky. Negate if s=1. Register out_data and flags. Go to DONE.
- Latency: out_valid first asserts in cycle N+2+k; special cases have k=0.
- DONE: out_valid=1. out_data and flags stay stable until out_valid&out_ready, then return to IDLE next cycle. out_valid drops, in_ready rises.
- No overlap: a new operand is never accepted in the same cycle the result is taken.
- Reset mid-operation (any state): immediate return to reset values; the in-flight operand is discarded.
- Widths: magnitude is 64 bits. Left shifts stop at e=62, so the magnitude never exceeds 2^63-2^39. Rounding carry needs no extra bit.

Optional Feature:
- Macro: F2I_RTZ_EN.
- Defined: adds input port rtz (1 bit), sampled with in_data at acceptance.
  - rtz=1 suppresses the ROUND increment (truncate toward zero); inx is still reported.
- Undefined: no rtz port; round-to-nearest-even only.

Decomposition:
- Package fp_conv_pkg:
  - state enum (IDLE, LOAD, SHIFT, ROUND, DONE)
  - BIAS
  - INT64_MAX and INT64_MIN saturation constants
  - field-slice localparams (sign bit 31, exponent 30:23, fraction 22:0)
- One natural sub-module: f2i_round_rne, combinational. Inputs: magnitude, guard, sticky, sign, rtz. Outputs: rounded signed result and inx.

Test Plan:
- 0x3FC00000 (1.5) accepted cycle N -> out_data=2 (tie to even), inx=1, out_valid at N+25 (k=23).
- 0x40200000 (2.5) -> out_data=2, inx=1. Then 0xC0400000 (-3.0) -> 64'hFFFF_FFFF_FFFF_FFFD, nf=1, inx=0.
- 0x5E800000 (2^62) -> 64'h4000_0000_0000_0000, k=39, out_valid at N+41. 0xDF000000 (-2^63) -> 64'h8000_0000_0000_0000, inv=0.
- 0x7FC00000 (NaN) -> 64'h7FFF_FFFF_FFFF_FFFF, inv=1, at N+2. 0xFF800000 (-inf) -> INT64_MIN, inv=1. 0x00000001 (denormal) -> 0, zf=1, inx=1.
- Back-pressure: out_ready held low 5 cycles after out_valid -> out_data and flags stable, in_ready=0 throughout. Release -> in_ready=1 the next cycle.
- rst_n pulsed low during SHIFT of 1.5 -> outputs return to reset values immediately. Operand 0x3F800000 then gives out_data=1, inv=0, inx=0.
